// File: rtl/gpu_dispatch.sv
// gpu_dispatch: device-side kernel launch responder.
// Splits a launch of thread_count threads into blocks of THREADS_PER_BLOCK,
// hands blocks one per cycle to the lowest-index free core, pulses the core's
// reset after each completion and raises done once every block has finished.
// Optional feature macro: GPU_DISPATCH_PERF_EN (kernel_cycles run-length counter).
module gpu_dispatch #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int TW                = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              thread_count,
  input  logic [NUM_CORES-1:0]    core_done,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [NUM_CORES-1:0]    core_reset,
  output logic [NUM_CORES*8-1:0]  core_block_id,
  output logic [NUM_CORES*TW-1:0] core_thread_count,
  output logic                    done,
  output logic [15:0]             kernel_cycles
);

  localparam int SHIFT = $clog2(THREADS_PER_BLOCK);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [7:0]           t_lat;
  logic [8:0]           total_blocks;
  logic [8:0]           dispatched;
  logic [8:0]           completed;
  logic [NUM_CORES-1:0] in_pulse;

  logic [NUM_CORES-1:0] counted;
  logic [NUM_CORES-1:0] grant;
  logic [8:0]           n_counted;
  logic                 found;
  logic [15:0]          remaining;
  logic [TW-1:0]        new_tc;
  logic [8:0]           blocks_needed;

  // Completion qualification, lowest-free-core selection and next block size
  always_comb begin
    counted   = core_done & core_start & {NUM_CORES{state == RUN}};
    n_counted = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      n_counted = n_counted + 9'(counted[i]);
    end
    grant = '0;
    found = 1'b0;
    if (state == RUN && dispatched < total_blocks) begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (!found && !core_start[i] && !in_pulse[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    remaining = 16'(t_lat) - (16'(dispatched) << SHIFT);
    if (remaining > 16'(THREADS_PER_BLOCK)) begin
      new_tc = TW'(THREADS_PER_BLOCK);
    end else begin
      new_tc = remaining[TW-1:0];
    end
    blocks_needed = (9'(thread_count) + 9'(THREADS_PER_BLOCK - 1)) >> SHIFT;
  end

  // Launch FSM with per-core run/reset bookkeeping; all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      t_lat             <= '0;
      total_blocks      <= '0;
      dispatched        <= '0;
      completed         <= '0;
      in_pulse          <= '0;
      done              <= 1'b0;
      core_start        <= '0;
      core_reset        <= '1;
      core_block_id     <= '0;
      core_thread_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            t_lat        <= thread_count;
            total_blocks <= blocks_needed;
            dispatched   <= '0;
            completed    <= '0;
            done         <= 1'b0;
            state        <= RUN;
          end
        end
        RUN: begin
          // retire, complete and grant are mutually exclusive per core
          for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (in_pulse[i]) begin
              in_pulse[i]   <= 1'b0;
              core_reset[i] <= 1'b0;
            end
            if (counted[i]) begin
              core_start[i] <= 1'b0;
              core_reset[i] <= 1'b1;
              in_pulse[i]   <= 1'b1;
            end
            if (grant[i]) begin
              core_start[i]                 <= 1'b1;
              core_reset[i]                 <= 1'b0;
              core_block_id[8*i +: 8]       <= dispatched[7:0];
              core_thread_count[TW*i +: TW] <= new_tc;
            end
          end
          if (|grant) begin
            dispatched <= dispatched + 9'd1;
          end
          completed <= completed + n_counted;
          if (completed == total_blocks) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GPU_DISPATCH_PERF_EN
  // Run-length counter: cleared on launch, counts RUN cycles, saturates, holds in DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kernel_cycles <= '0;
    end else if (state != RUN && start) begin
      kernel_cycles <= '0;
    end else if (state == RUN && kernel_cycles != 16'hFFFF) begin
      kernel_cycles <= kernel_cycles + 16'd1;
    end
  end
`else
  assign kernel_cycles = '0;
`endif

endmodule

// File: tb/tb_gpu_dispatch.sv
// Self-checking bench for gpu_dispatch: directed launch scenarios plus
// randomized kernels against a block-level reference model.
module tb_gpu_dispatch;

  localparam int NC  = 2;
  localparam int TPB = 4;
  localparam int TW  = $clog2(TPB) + 1;

  logic             clk;
  logic             reset;
  logic             start;
  logic [7:0]       thread_count;
  logic [NC-1:0]    core_done;
  logic [NC-1:0]    core_start;
  logic [NC-1:0]    core_reset;
  logic [NC*8-1:0]  core_block_id;
  logic [NC*TW-1:0] core_thread_count;
  logic             done;
  logic [15:0]      kernel_cycles;

  gpu_dispatch #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) dut (
    .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
    .core_done(core_done), .core_start(core_start), .core_reset(core_reset),
    .core_block_id(core_block_id), .core_thread_count(core_thread_count),
    .done(done), .kernel_cycles(kernel_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: kernel-level view (busy/cooling/free per core)
  int m_run = 0, m_done = 0, m_T = 0, m_nb = 0, m_next = 0, m_fin = 0, m_kc = 0;
  int stage [NC];   // 0 free, 1 running a block, 2 in reset pulse
  int m_rst [NC];
  int m_blk [NC];
  int m_tc  [NC];
  int f_core, fin_before;

  bit auto_mode = 0;
  int lat [NC];
  bit was_run [NC];

  task automatic model_reset();
    m_run = 0; m_done = 0; m_T = 0; m_nb = 0; m_next = 0; m_fin = 0; m_kc = 0;
    for (int i = 0; i < NC; i++) begin
      stage[i] = 0; m_rst[i] = 1; m_blk[i] = 0; m_tc[i] = 0;
    end
  endtask

  initial model_reset();

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_reset();
    end else if (m_run == 0) begin
      if (start) begin
        m_T = thread_count; m_nb = (m_T + TPB - 1) / TPB;
        m_next = 0; m_fin = 0; m_run = 1; m_done = 0; m_kc = 0;
      end
    end else begin
      if (m_kc < 65535) m_kc++;
      fin_before = m_fin;
      f_core = -1;
      if (m_next < m_nb)
        for (int i = 0; i < NC; i++) if (f_core < 0 && stage[i] == 0) f_core = i;
      for (int i = 0; i < NC; i++) begin
        if (stage[i] == 2) begin
          stage[i] = 0; m_rst[i] = 0;
        end else if (stage[i] == 1 && core_done[i]) begin
          stage[i] = 2; m_rst[i] = 1; m_fin++;
        end
      end
      if (f_core >= 0) begin
        stage[f_core] = 1; m_rst[f_core] = 0; m_blk[f_core] = m_next;
        m_tc[f_core] = (m_T - m_next * TPB > TPB) ? TPB : m_T - m_next * TPB;
        m_next++;
      end
      if (fin_before == m_nb) begin
        m_run = 0; m_done = 1;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Single per-cycle comparison of every output against the model
  task automatic compare();
    logic [NC-1:0]    es, er;
    logic [NC*8-1:0]  eb;
    logic [NC*TW-1:0] et;
    int ekc;
    for (int i = 0; i < NC; i++) begin
      es[i] = (stage[i] == 1);
      er[i] = m_rst[i][0];
      eb[8*i +: 8] = m_blk[i][7:0];
      et[TW*i +: TW] = m_tc[i][TW-1:0];
    end
`ifdef GPU_DISPATCH_PERF_EN
    ekc = m_kc;
`else
    ekc = 0;
`endif
    chk("done", 32'(done), 32'(m_done));
    chk("core_start", 32'(core_start), 32'(es));
    chk("core_reset", 32'(core_reset), 32'(er));
    chk("core_block_id", 32'(core_block_id), 32'(eb));
    chk("core_thread_count", 32'(core_thread_count), 32'(et));
    chk("kernel_cycles", 32'(kernel_cycles), 32'(ekc));
  endtask

  // Randomized core responder: finishes each block after a random latency,
  // plus spurious done/start noise that must be ignored
  task automatic drive_auto();
    for (int i = 0; i < NC; i++) begin
      if (stage[i] == 1) begin
        if (!was_run[i]) lat[i] = $urandom_range(0, 5);
        if (lat[i] == 0) core_done[i] = 1'b1;
        else begin core_done[i] = 1'b0; lat[i]--; end
      end else begin
        core_done[i] = ($urandom_range(0, 5) == 0);
      end
      was_run[i] = (stage[i] == 1);
    end
    if (m_run != 0) begin
      start = ($urandom_range(0, 7) == 0);
      thread_count = 8'($urandom_range(0, 255));
    end else begin
      start = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    if (auto_mode) drive_auto();
  endtask

  task automatic wait_done(int bound);
    int n = 0;
    while (m_done == 0 && n < bound) begin step(); n++; end
    if (m_done == 0) begin
      n_chk++;
      $display("FAIL wait_done: no completion within %0d cycles", bound);
    end
  endtask

  task automatic launch(int t);
    start = 1'b1; thread_count = 8'(t);
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; thread_count = '0; core_done = '0;
    for (int i = 0; i < NC; i++) begin lat[i] = 0; was_run[i] = 0; end
    #1;
    chk("rst_core_reset", 32'(core_reset), 32'h3);
    chk("rst_core_start", 32'(core_start), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    step(); step();
    reset = 1'b0;
    step();

    // T=4: only core 0, block 0, four threads
    launch(4);
    step();
    chk("A_core_start", 32'(core_start), 32'h1);
    chk("A_block_id0", 32'(core_block_id[7:0]), 32'h0);
    chk("A_tc0", 32'(core_thread_count[TW-1:0]), 32'h4);
    step(); step();
    core_done = 2'b01; step();
    chk("A_reset_pulse", 32'(core_reset), 32'h3);
    core_done = 2'b00; step();
    chk("A_done", 32'(done), 32'h1);
    chk("A_reset_end", 32'(core_reset), 32'h2);
    step();

    // T=10: blocks 0,1 on both cores, block 2 (2 threads) on the freed core
    launch(10);
    step(); step();
    chk("B_both_run", 32'(core_start), 32'h3);
    core_done = 2'b01; step();
    core_done = 2'b00; step(); step();
    chk("B_reassign", 32'(core_start), 32'h3);
    chk("B_blk2", 32'(core_block_id[7:0]), 32'h2);
    chk("B_tc2", 32'(core_thread_count[TW-1:0]), 32'h2);
    chk("B_blk1", 32'(core_block_id[15:8]), 32'h1);
    core_done = 2'b11; step();
    core_done = 2'b00; step();
    chk("B_done", 32'(done), 32'h1);

    // T=0: straight to done, no core activity
    launch(0);
    chk("C_not_done_yet", 32'(done), 32'h0);
    step();
    chk("C_done", 32'(done), 32'h1);
    chk("C_no_start", 32'(core_start), 32'h0);

    // T=8: simultaneous completion on both cores
    launch(8);
    step(); step();
    core_done = 2'b11; step();
    chk("D_both_pulse", 32'(core_reset), 32'h3);
    chk("D_both_stop", 32'(core_start), 32'h0);
    core_done = 2'b00; step();
    chk("D_done", 32'(done), 32'h1);
    chk("D_pulse_end", 32'(core_reset), 32'h0);

`ifdef GPU_DISPATCH_PERF_EN
    // T=4, done sampled 6 cycles after core_start: 8 RUN cycles
    launch(4);
    step();
    repeat (5) step();
    core_done = 2'b01; step();
    core_done = 2'b00; step();
    chk("P_done", 32'(done), 32'h1);
    chk("P_kc", 32'(kernel_cycles), 32'd8);
    step();
    chk("P_kc_hold", 32'(kernel_cycles), 32'd8);
    launch(4);
    chk("P_kc_clear", 32'(kernel_cycles), 32'd0);
    step(); step();
    core_done = 2'b01; step();
    core_done = 2'b00; step(); step();
`endif

    // Reset mid-run with two blocks in flight
    launch(10);
    step(); step();
    #2 reset = 1'b1;
    #1;
    chk("E_start", 32'(core_start), 32'h0);
    chk("E_reset", 32'(core_reset), 32'h3);
    chk("E_done", 32'(done), 32'h0);
    chk("E_blk", 32'(core_block_id), 32'h0);
    chk("E_tc", 32'(core_thread_count), 32'h0);
    chk("E_kc", 32'(kernel_cycles), 32'h0);
    step();
    reset = 1'b0;
    step();
    auto_mode = 1;
    launch(4);
    wait_done(200);
    chk("E_relaunch_done", 32'(done), 32'h1);

    // Random kernels back-to-back from DONE with noisy inputs
    for (int k = 0; k < 25; k++) begin
      launch((k % 5 == 0) ? $urandom_range(0, 9) : $urandom_range(0, 255));
      wait_done(3000);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
